// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set 2 scancode decoder: handles the F0/E0 prefixes, tracks Shift
// and Caps Lock, and queues make events in a show-ahead FIFO.
module ps2_scancode_decoder #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     code_valid,
  input  logic [7:0]               code_byte,
  input  logic                     rd_en,
  output logic [7:0]               key_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     shift_held,
  output logic                     caps_lock
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BRK,
    S_EXT,
    S_EXT_BRK
  } state_e;

  state_e state_q, state_d;
  logic lsh_q, lsh_d, rsh_q, rsh_d;
  logic caps_q, caps_d;
  logic push;
  logic [7:0] push_data;
  logic [8:0] nm, em;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          ovf_q;
  logic          do_push, do_pop;

  // Bit 8 flags a mapped code; bits 7:0 carry the ASCII/key value.
  function automatic logic [8:0] map_normal(input logic [7:0] c,
                                            input logic up);
    logic [7:0] ltr, oth;
    ltr = 8'h00;
    oth = 8'h00;
    case (c)
      8'h1C: ltr = 8'h61;
      8'h32: ltr = 8'h62;
      8'h21: ltr = 8'h63;
      8'h23: ltr = 8'h64;
      8'h24: ltr = 8'h65;
      8'h2B: ltr = 8'h66;
      8'h34: ltr = 8'h67;
      8'h33: ltr = 8'h68;
      8'h43: ltr = 8'h69;
      8'h3B: ltr = 8'h6A;
      8'h42: ltr = 8'h6B;
      8'h4B: ltr = 8'h6C;
      8'h3A: ltr = 8'h6D;
      8'h31: ltr = 8'h6E;
      8'h44: ltr = 8'h6F;
      8'h4D: ltr = 8'h70;
      8'h15: ltr = 8'h71;
      8'h2D: ltr = 8'h72;
      8'h1B: ltr = 8'h73;
      8'h2C: ltr = 8'h74;
      8'h3C: ltr = 8'h75;
      8'h2A: ltr = 8'h76;
      8'h1D: ltr = 8'h77;
      8'h22: ltr = 8'h78;
      8'h35: ltr = 8'h79;
      8'h1A: ltr = 8'h7A;
      8'h45: oth = 8'h30;
      8'h16: oth = 8'h31;
      8'h1E: oth = 8'h32;
      8'h26: oth = 8'h33;
      8'h25: oth = 8'h34;
      8'h2E: oth = 8'h35;
      8'h36: oth = 8'h36;
      8'h3D: oth = 8'h37;
      8'h3E: oth = 8'h38;
      8'h46: oth = 8'h39;
      8'h29: oth = 8'h20;
      8'h5A: oth = 8'h0D;
      8'h66: oth = 8'h08;
      8'h76: oth = 8'h1B;
      8'h0D: oth = 8'h09;
      default: ;
    endcase
    if (ltr != 8'h00)
      return {1'b1, up ? (ltr - 8'h20) : ltr};
    if (oth != 8'h00)
      return {1'b1, oth};
    return 9'h000;
  endfunction

  function automatic logic [8:0] map_ext(input logic [7:0] c);
    case (c)
      8'h75:   return 9'h180;
      8'h72:   return 9'h181;
      8'h6B:   return 9'h182;
      8'h74:   return 9'h183;
      8'h6C:   return 9'h184;
      8'h69:   return 9'h185;
      8'h71:   return 9'h17F;
      8'h5A:   return 9'h10D;
      default: return 9'h000;
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    lsh_d     = lsh_q;
    rsh_d     = rsh_q;
    caps_d    = caps_q;
    push      = 1'b0;
    push_data = 8'h00;
    nm = map_normal(code_byte, (lsh_q | rsh_q) ^ caps_q);
    em = map_ext(code_byte);
    if (code_valid) begin
      case (state_q)
        S_IDLE: begin
          if (code_byte == 8'hF0) state_d = S_BRK;
          else if (code_byte == 8'hE0) state_d = S_EXT;
          else if (code_byte == 8'hFA || code_byte == 8'hAA ||
                   code_byte == 8'hEE || code_byte == 8'hFE) ;
          else if (code_byte == 8'h12) lsh_d = 1'b1;
          else if (code_byte == 8'h59) rsh_d = 1'b1;
          else if (code_byte == 8'h58) caps_d = ~caps_q;
          else begin
            push      = nm[8];
            push_data = nm[7:0];
          end
        end
        S_BRK: begin
          state_d = S_IDLE;
          if (code_byte == 8'h12) lsh_d = 1'b0;
          if (code_byte == 8'h59) rsh_d = 1'b0;
        end
        S_EXT: begin
          if (code_byte == 8'hF0) state_d = S_EXT_BRK;
          else begin
            state_d   = S_IDLE;
            push      = em[8];
            push_data = em[7:0];
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      lsh_q   <= 1'b0;
      rsh_q   <= 1'b0;
      caps_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lsh_q   <= lsh_d;
      rsh_q   <= rsh_d;
      caps_q  <= caps_d;
    end
  end

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == FULL_CNT);
  assign do_pop  = rd_en & ~empty;
  // A pop in the same cycle frees the slot a full FIFO needs.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      if (do_push && !do_pop) cnt_q <= cnt_q + 1'b1;
      else if (!do_push && do_pop) cnt_q <= cnt_q - 1'b1;
      if (push && !do_push) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_data;
  end

  assign key_data   = empty ? 8'h00 : mem_q[rd_q];
  assign count      = cnt_q;
  assign overflow   = ovf_q;
  assign shift_held = lsh_q | rsh_q;
  assign caps_lock  = caps_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Self-checking bench for ps2_scancode_decoder: directed vector table,
// hand-written corner sequences and random traffic against a queue model.
module tb_ps2_scancode_decoder;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       code_valid;
  logic [7:0] code_byte;
  logic       rd_en;
  logic [7:0] key_data;
  logic       empty, full, overflow, shift_held, caps_lock;
  logic [3:0] count;

  int pass_cnt = 0;
  int total_cnt = 0;

  ps2_scancode_decoder #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .code_valid (code_valid),
    .code_byte  (code_byte),
    .rd_en      (rd_en),
    .key_data   (key_data),
    .empty      (empty),
    .full       (full),
    .count      (count),
    .overflow   (overflow),
    .shift_held (shift_held),
    .caps_lock  (caps_lock)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0] mq[$];
  bit m_lsh, m_rsh, m_caps, m_ovf, m_brk, m_ext;

  logic [7:0] LET [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B,
    8'h34, 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44,
    8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
    8'h35, 8'h1A};
  logic [7:0] DIG [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
    8'h36, 8'h3D, 8'h3E, 8'h46};
  logic [7:0] POOL [12] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h6C, 8'h69,
    8'h71, 8'h5A, 8'h29, 8'h66, 8'h76, 8'h0D};

  function automatic int norm_key(logic [7:0] b, bit up);
    for (int i = 0; i < 26; i++)
      if (LET[i] == b) return up ? 32'h41 + i : 32'h61 + i;
    for (int i = 0; i < 10; i++)
      if (DIG[i] == b) return 32'h30 + i;
    case (b)
      8'h29: return 32'h20;
      8'h5A: return 32'h0D;
      8'h66: return 32'h08;
      8'h76: return 32'h1B;
      8'h0D: return 32'h09;
      default: return -1;
    endcase
  endfunction

  function automatic int ext_key(logic [7:0] b);
    case (b)
      8'h75: return 32'h80;
      8'h72: return 32'h81;
      8'h6B: return 32'h82;
      8'h74: return 32'h83;
      8'h6C: return 32'h84;
      8'h69: return 32'h85;
      8'h71: return 32'h7F;
      8'h5A: return 32'h0D;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    mq.delete();
    m_lsh = 0; m_rsh = 0; m_caps = 0; m_ovf = 0; m_brk = 0; m_ext = 0;
  endtask

  task automatic model_step(bit v, logic [7:0] b, bit rd);
    int key;
    int pre_n;
    bit pop;
    bit up;
    key = -1;
    up = (m_lsh | m_rsh) ^ m_caps;
    if (v) begin
      if (m_brk) begin
        if (!m_ext) begin
          if (b == 8'h12) m_lsh = 0;
          if (b == 8'h59) m_rsh = 0;
        end
        m_brk = 0; m_ext = 0;
      end else if (m_ext) begin
        if (b == 8'hF0) m_brk = 1;
        else begin
          key = ext_key(b);
          m_ext = 0;
        end
      end else if (b == 8'hF0) m_brk = 1;
      else if (b == 8'hE0) m_ext = 1;
      else if (b inside {8'hFA, 8'hAA, 8'hEE, 8'hFE}) ;
      else if (b == 8'h12) m_lsh = 1;
      else if (b == 8'h59) m_rsh = 1;
      else if (b == 8'h58) m_caps = !m_caps;
      else key = norm_key(b, up);
    end
    pre_n = mq.size();
    pop = rd && pre_n > 0;
    if (pop) void'(mq.pop_front());
    if (key >= 0) begin
      if (mq.size() < DEPTH) mq.push_back(key[7:0]);
      else m_ovf = 1;
    end
  endtask

  task automatic chk(string nm, int got, int exp);
    total_cnt++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  task automatic chk_model(string tag);
    int ek;
    ek = (mq.size() > 0) ? int'(mq[0]) : 0;
    chk({tag, " key_data"}, key_data, ek);
    chk({tag, " count"}, count, mq.size());
    chk({tag, " empty"}, empty, mq.size() == 0);
    chk({tag, " full"}, full, mq.size() == DEPTH);
    chk({tag, " overflow"}, overflow, m_ovf);
    chk({tag, " shift_held"}, shift_held, m_lsh | m_rsh);
    chk({tag, " caps_lock"}, caps_lock, m_caps);
  endtask

  task automatic cyc(bit v, logic [7:0] b, bit rd);
    code_valid = v;
    code_byte = b;
    rd_en = rd;
    @(posedge clk);
    model_step(v, b, rd);
    #1;
    code_valid = 0;
    code_byte = 8'h00;
    rd_en = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    code_valid = 0;
    code_byte = 8'h00;
    rd_en = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  typedef struct {
    bit         v;
    logic [7:0] b;
    bit         rd;
    logic [7:0] k;
    int         n;
    bit         sh;
    bit         cp;
  } vec_t;

  vec_t tbl [30];

  initial begin
    tbl[0]  = '{1, 8'h1C, 0, 8'h61, 1, 0, 0};
    tbl[1]  = '{1, 8'hF0, 0, 8'h61, 1, 0, 0};
    tbl[2]  = '{1, 8'h1C, 0, 8'h61, 1, 0, 0};
    tbl[3]  = '{0, 8'h00, 1, 8'h00, 0, 0, 0};
    tbl[4]  = '{1, 8'h12, 0, 8'h00, 0, 1, 0};
    tbl[5]  = '{1, 8'h1C, 0, 8'h41, 1, 1, 0};
    tbl[6]  = '{1, 8'hF0, 0, 8'h41, 1, 1, 0};
    tbl[7]  = '{1, 8'h12, 0, 8'h41, 1, 0, 0};
    tbl[8]  = '{1, 8'h1C, 0, 8'h41, 2, 0, 0};
    tbl[9]  = '{0, 8'h00, 1, 8'h61, 1, 0, 0};
    tbl[10] = '{0, 8'h00, 1, 8'h00, 0, 0, 0};
    tbl[11] = '{1, 8'h58, 0, 8'h00, 0, 0, 1};
    tbl[12] = '{1, 8'hF0, 0, 8'h00, 0, 0, 1};
    tbl[13] = '{1, 8'h58, 0, 8'h00, 0, 0, 1};
    tbl[14] = '{1, 8'h1C, 0, 8'h41, 1, 0, 1};
    tbl[15] = '{1, 8'h12, 0, 8'h41, 1, 1, 1};
    tbl[16] = '{1, 8'h1C, 0, 8'h41, 2, 1, 1};
    tbl[17] = '{0, 8'h00, 1, 8'h61, 1, 1, 1};
    tbl[18] = '{0, 8'h00, 1, 8'h00, 0, 1, 1};
    tbl[19] = '{1, 8'hE0, 0, 8'h00, 0, 1, 1};
    tbl[20] = '{1, 8'h75, 0, 8'h80, 1, 1, 1};
    tbl[21] = '{1, 8'hE0, 0, 8'h80, 1, 1, 1};
    tbl[22] = '{1, 8'hF0, 0, 8'h80, 1, 1, 1};
    tbl[23] = '{1, 8'h75, 0, 8'h80, 1, 1, 1};
    tbl[24] = '{1, 8'hE0, 0, 8'h80, 1, 1, 1};
    tbl[25] = '{1, 8'h71, 0, 8'h80, 2, 1, 1};
    tbl[26] = '{1, 8'h16, 0, 8'h80, 3, 1, 1};
    tbl[27] = '{0, 8'h00, 1, 8'h7F, 2, 1, 1};
    tbl[28] = '{0, 8'h00, 1, 8'h31, 1, 1, 1};
    tbl[29] = '{0, 8'h00, 1, 8'h00, 0, 1, 1};

    do_reset();
    chk("reset key_data", key_data, 0);
    chk("reset count", count, 0);
    chk("reset empty", empty, 1);
    chk("reset full", full, 0);
    chk("reset overflow", overflow, 0);
    chk("reset shift_held", shift_held, 0);
    chk("reset caps_lock", caps_lock, 0);

    for (int i = 0; i < 30; i++) begin
      cyc(tbl[i].v, tbl[i].b, tbl[i].rd);
      chk($sformatf("vec%0d key_data", i), key_data, tbl[i].k);
      chk($sformatf("vec%0d count", i), count, tbl[i].n);
      chk($sformatf("vec%0d shift_held", i), shift_held, tbl[i].sh);
      chk($sformatf("vec%0d caps_lock", i), caps_lock, tbl[i].cp);
    end

    // Fill past DEPTH, then simultaneous push/pop while full, then drain.
    do_reset();
    for (int i = 0; i < 9; i++) cyc(1, 8'h1C, 0);
    chk("ovf full", full, 1);
    chk("ovf count", count, 8);
    chk("ovf overflow", overflow, 1);
    cyc(1, 8'h1C, 1);
    chk("full push+pop count", count, 8);
    chk("full push+pop full", full, 1);
    for (int i = 0; i < 8; i++) cyc(0, 8'h00, 1);
    chk("drain empty", empty, 1);
    chk("drain key_data", key_data, 0);
    chk("drain count", count, 0);
    chk("drain overflow sticky", overflow, 1);
    cyc(1, 8'h32, 1);
    chk("empty push+pop count", count, 1);
    chk("empty push+pop key", key_data, 8'h62);

    // Reset in the middle of an E0 prefix discards the prefix.
    do_reset();
    cyc(1, 8'h58, 0);
    cyc(1, 8'h59, 0);
    cyc(1, 8'hE0, 0);
    rst_n = 0;
    model_reset();
    #1;
    chk("async rst caps_lock", caps_lock, 0);
    chk("async rst shift_held", shift_held, 0);
    @(posedge clk);
    #1 rst_n = 1;
    cyc(1, 8'h75, 0);
    chk("mid-prefix count", count, 0);
    chk("mid-prefix empty", empty, 1);
    chk("mid-prefix caps_lock", caps_lock, 0);
    chk("mid-prefix shift_held", shift_held, 0);

    // Random traffic against the model, with varying read pressure.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      bit v;
      bit rd;
      logic [7:0] b;
      int r;
      int rdpct;
      rdpct = ((n / 500) % 2 == 0) ? 25 : 70;
      v = $urandom_range(0, 3) != 0;
      rd = $urandom_range(0, 99) < rdpct;
      r = $urandom_range(0, 11);
      case (r)
        0, 1: b = 8'hF0;
        2:    b = 8'hE0;
        3:    b = ($urandom_range(0, 1) != 0) ? 8'h12 : 8'h59;
        4:    b = 8'h58;
        5:    b = 8'($urandom_range(0, 255));
        6:    b = DIG[$urandom_range(0, 9)];
        7, 8: b = POOL[$urandom_range(0, 11)];
        default: b = LET[$urandom_range(0, 25)];
      endcase
      cyc(v, b, rd);
      chk_model($sformatf("rand%0d", n));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
